jesd204_rx_link_ctrl_64b: RTL and testbench

JESD204_RX_LINK_CTRL_64B -- requirements
Module: jesd204_rx_link_ctrl_64b

---
 rtl/jesd204_rx_link_ctrl_64b.sv | 127 ++++++++++++
 tb/tb_jesd204_rx_link_ctrl_64b.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_rx_link_ctrl_64b.sv
// JESD204C 64b/66b receive link controller: lane qualification FSM, sticky lane faults, error pulse.
// Optional saturating error counter enabled by defining JESD204_RX_LINK_ERR_CNT_EN.
module jesd204_rx_link_ctrl_64b #(
   parameter int unsigned NUM_LANES      = 1,
   parameter int unsigned GOOD_CNT_WIDTH = 6,
   parameter int unsigned ERR_CNT_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_LANES-1:0]      cfg_lanes_disable,
   input  logic [GOOD_CNT_WIDTH-1:0] cfg_good_cnt_limit,
   input  logic [NUM_LANES-1:0]      phy_block_sync,
   input  logic [NUM_LANES-1:0]      emb_lock,
   input  logic                      buffer_release_n,
   input  logic                      status_lane_fault_clr,
   output logic                      all_emb_lock,
   output logic [1:0]                status_state,
   output logic [NUM_LANES-1:0]      status_lane_fault,
   output logic                      event_unexpected_lane_state_error,
   output logic [ERR_CNT_WIDTH-1:0]  status_err_cnt
);

   typedef enum logic [1:0] {
      StReset     = 2'd0,
      StWaitBs    = 2'd1,
      StBlockSync = 2'd2,
      StData      = 2'd3
   } state_e;

   state_e                    state;
   logic [GOOD_CNT_WIDTH-1:0] good_cnt;
   logic [NUM_LANES-1:0]      emb_lock_d;
   logic                      buffer_release_d_n;
   logic                      all_block_sync;
   logic                      qualify;
   logic                      cnt_hit;
   logic                      cnt_over;
   logic [NUM_LANES-1:0]      fault_set;

   always_comb begin
      all_block_sync = &(phy_block_sync | cfg_lanes_disable);
      all_emb_lock   = &(emb_lock_d | cfg_lanes_disable);
      qualify        = 1'b0;
      if (state == StWaitBs) begin
         qualify = all_block_sync;
      end else if (state == StBlockSync) begin
         qualify = all_block_sync & all_emb_lock & ~buffer_release_d_n;
      end
      cnt_hit   = (good_cnt == cfg_good_cnt_limit);
      cnt_over  = (good_cnt > cfg_good_cnt_limit);
      fault_set = {NUM_LANES{state == StData}} & ~cfg_lanes_disable &
                  (~phy_block_sync | ~emb_lock_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                             <= StReset;
         good_cnt                          <= '0;
         emb_lock_d                        <= '0;
         buffer_release_d_n                <= 1'b1;
         status_lane_fault                 <= '0;
         event_unexpected_lane_state_error <= 1'b0;
      end else begin
         emb_lock_d                        <= emb_lock;
         buffer_release_d_n                <= buffer_release_n;
         event_unexpected_lane_state_error <= 1'b0;
         // A new fault on the same cycle as a clear must survive the clear.
         if (status_lane_fault_clr) begin
            status_lane_fault <= fault_set;
         end else begin
            status_lane_fault <= status_lane_fault | fault_set;
         end

         case (state)
            StReset: begin
               state    <= StWaitBs;
               good_cnt <= '0;
            end
            StWaitBs, StBlockSync: begin
               if (state == StBlockSync && !all_block_sync) begin
                  state    <= StWaitBs;
                  good_cnt <= '0;
               end else if (!qualify) begin
                  good_cnt <= '0;
               end else if (cnt_hit) begin
                  state    <= (state == StWaitBs) ? StBlockSync : StData;
                  good_cnt <= '0;
               end else if (cnt_over) begin
                  // Limit was lowered below the running count: start over.
                  good_cnt <= '0;
               end else begin
                  good_cnt <= good_cnt + 1'b1;
               end
            end
            StData: begin
               good_cnt <= '0;
               if (!all_block_sync) begin
                  state                             <= StWaitBs;
                  event_unexpected_lane_state_error <= 1'b1;
               end else if (!all_emb_lock || buffer_release_d_n) begin
                  state                             <= StBlockSync;
                  event_unexpected_lane_state_error <= 1'b1;
               end
            end
            default: begin
               state    <= StReset;
               good_cnt <= '0;
            end
         endcase
      end
   end

   assign status_state = state;

`ifdef JESD204_RX_LINK_ERR_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status_err_cnt <= '0;
      end else if (event_unexpected_lane_state_error && (status_err_cnt != '1)) begin
         status_err_cnt <= status_err_cnt + 1'b1;
      end
   end
`else
   assign status_err_cnt = '0;
`endif

endmodule

// File: tb/tb_jesd204_rx_link_ctrl_64b.sv
// Bench for jesd204_rx_link_ctrl_64b: directed scenarios plus random stimulus against a cycle model.
module tb_jesd204_rx_link_ctrl_64b;
   localparam int NL = 4;
   localparam int GW = 6;
   localparam int EW = 2;
   localparam int ERR_MAX = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [NL-1:0] cfg_lanes_disable;
   logic [GW-1:0] cfg_good_cnt_limit;
   logic [NL-1:0] phy_block_sync;
   logic [NL-1:0] emb_lock;
   logic          buffer_release_n;
   logic          status_lane_fault_clr;
   logic          all_emb_lock;
   logic [1:0]    status_state;
   logic [NL-1:0] status_lane_fault;
   logic          event_unexpected_lane_state_error;
   logic [EW-1:0] status_err_cnt;

   jesd204_rx_link_ctrl_64b #(
      .NUM_LANES(NL), .GOOD_CNT_WIDTH(GW), .ERR_CNT_WIDTH(EW)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_lanes_disable(cfg_lanes_disable), .cfg_good_cnt_limit(cfg_good_cnt_limit),
      .phy_block_sync(phy_block_sync), .emb_lock(emb_lock),
      .buffer_release_n(buffer_release_n), .status_lane_fault_clr(status_lane_fault_clr),
      .all_emb_lock(all_emb_lock), .status_state(status_state),
      .status_lane_fault(status_lane_fault),
      .event_unexpected_lane_state_error(event_unexpected_lane_state_error),
      .status_err_cnt(status_err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: link phase (0..3), run of consecutive good cycles, pipelined inputs.
   int            m_state, m_cnt, m_err, m_pulses;
   logic [NL-1:0] m_emb_d, m_fault;
   logic          m_rel_d, m_pulse;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_err = 0; m_emb_d = '0; m_fault = '0;
      m_rel_d = 1'b1; m_pulse = 1'b0;
   endtask

   task automatic check_all();
      int exp_err;
`ifdef JESD204_RX_LINK_ERR_CNT_EN
      exp_err = m_err;
`else
      exp_err = 0;
`endif
      chk("state", 32'(status_state), 32'(m_state));
      chk("lane_fault", 32'(status_lane_fault), 32'(m_fault));
      chk("err_pulse", 32'(event_unexpected_lane_state_error), 32'(m_pulse));
      chk("err_cnt", 32'(status_err_cnt), 32'(exp_err));
      chk("all_emb_lock", 32'(all_emb_lock), 32'(&(m_emb_d | cfg_lanes_disable)));
   endtask

   task automatic step();
      logic abs, aem, qual, np;
      int ns, nc, lim, ne;
      logic [NL-1:0] fset, nf;
      abs  = &(phy_block_sync | cfg_lanes_disable);
      aem  = &(m_emb_d | cfg_lanes_disable);
      lim  = int'(cfg_good_cnt_limit);
      ns   = m_state; nc = m_cnt; np = 1'b0;
      case (m_state)
         0: begin ns = 1; nc = 0; end
         1, 2: begin
            qual = abs && (m_state == 1 || (aem && !m_rel_d));
            if (m_state == 2 && !abs) begin ns = 1; nc = 0; end
            else if (!qual) nc = 0;
            else if (m_cnt == lim) begin ns = m_state + 1; nc = 0; end
            else if (m_cnt > lim) nc = 0;
            else nc = m_cnt + 1;
         end
         default: begin
            nc = 0;
            if (!abs) begin ns = 1; np = 1'b1; end
            else if (!aem || m_rel_d) begin ns = 2; np = 1'b1; end
         end
      endcase
      fset = (m_state == 3) ? (~cfg_lanes_disable & (~phy_block_sync | ~m_emb_d)) : '0;
      nf   = status_lane_fault_clr ? fset : (m_fault | fset);
      ne   = (m_pulse && m_err < ERR_MAX) ? m_err + 1 : m_err;
      @(posedge clk);
      #1;
      m_state = ns; m_cnt = nc; m_pulse = np; m_fault = nf; m_err = ne;
      m_emb_d = emb_lock; m_rel_d = buffer_release_n;
      if (np) m_pulses++;
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int exp_sat;
      m_pulses = 0;
      reset = 1'b1;
      cfg_lanes_disable = '0; cfg_good_cnt_limit = 6'd63;
      phy_block_sync = '1; emb_lock = '1; buffer_release_n = 1'b0;
      status_lane_fault_clr = 1'b0;

      // Full qualification with all lanes good.
      do_reset();
      step();
      chk("wait_bs_at_1", 32'(status_state), 32'd1);
      steps(63);
      chk("still_wait_bs", 32'(status_state), 32'd1);
      step();
      chk("block_sync_after_64", 32'(status_state), 32'd2);
      steps(64);
      chk("data_after_64", 32'(status_state), 32'd3);
      chk("no_pulses_bringup", 32'(m_pulses), 32'd0);

      // Lane 2 loses block sync for one cycle.
      phy_block_sync = 4'b1011;
      step();
      phy_block_sync = '1;
      chk("drop_lane2_state", 32'(status_state), 32'd1);
      chk("drop_lane2_pulse", 32'(event_unexpected_lane_state_error), 32'd1);
      chk("drop_lane2_fault", 32'(status_lane_fault), 32'b0100);
      step();
`ifdef JESD204_RX_LINK_ERR_CNT_EN
      chk("drop_lane2_errcnt", 32'(status_err_cnt), 32'd1);
`endif

      // Disabled lane 3 with dead signals still lets the link reach DATA.
      do_reset();
      cfg_lanes_disable = 4'b1000; phy_block_sync = 4'b0111; emb_lock = 4'b0111;
      steps(129);
      chk("disabled_lane_data", 32'(status_state), 32'd3);
      chk("disabled_lane_fault", 32'(status_lane_fault), 32'd0);
      cfg_lanes_disable = '0; phy_block_sync = '1; emb_lock = '1;

      // Limit 0, buffer release toggling in DATA, five exits to saturate the counter.
      do_reset();
      cfg_good_cnt_limit = 6'd0;
      steps(3);
      chk("lim0_data", 32'(status_state), 32'd3);
      for (int k = 0; k < 5; k++) begin
         buffer_release_n = 1'b1;
         steps(2);
         chk("release_exit_state", 32'(status_state), 32'd2);
         chk("release_exit_pulse", 32'(event_unexpected_lane_state_error), 32'd1);
         buffer_release_n = 1'b0;
         steps(2);
         chk("release_back_data", 32'(status_state), 32'd3);
      end
`ifdef JESD204_RX_LINK_ERR_CNT_EN
      exp_sat = 3;
`else
      exp_sat = 0;
`endif
      chk("err_cnt_saturated", 32'(status_err_cnt), 32'(exp_sat));

      // Fault clear collides with a new fault on lane 0.
      phy_block_sync = 4'b1110;
      step();
      phy_block_sync = '1;
      status_lane_fault_clr = 1'b1;
      step();
      status_lane_fault_clr = 1'b0;
      steps(3);
      phy_block_sync = 4'b1110; status_lane_fault_clr = 1'b1;
      step();
      chk("clr_vs_set_lane0", 32'(status_lane_fault), 32'b0001);
      phy_block_sync = '1; status_lane_fault_clr = 1'b0;

      // Randomized traffic, including mid-count limit changes.
      for (int i = 0; i < 3000; i++) begin
         for (int l = 0; l < NL; l++) begin
            phy_block_sync[l] = ($urandom_range(0, 40) != 0);
            emb_lock[l]       = ($urandom_range(0, 40) != 0);
         end
         if ($urandom_range(0, 30) == 0) buffer_release_n = ~buffer_release_n;
         if ($urandom_range(0, 200) == 0) cfg_lanes_disable = NL'($urandom_range(0, 15));
         if ($urandom_range(0, 50) == 0) cfg_good_cnt_limit = GW'($urandom_range(0, 6));
         status_lane_fault_clr = ($urandom_range(0, 7) == 0);
         step();
      end
      status_lane_fault_clr = 1'b0;
      cfg_lanes_disable = '0; phy_block_sync = '1; emb_lock = '1; buffer_release_n = 1'b0;

      // Reset in the middle of a WAIT_BS count, then full requalification.
      cfg_good_cnt_limit = 6'd63;
      do_reset();
      steps(31);
      chk("mid_count_wait_bs", 32'(status_state), 32'd1);
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("reset_no_pulse", 32'(event_unexpected_lane_state_error), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      steps(64);
      chk("restart_not_early", 32'(status_state), 32'd1);
      step();
      chk("restart_full_64", 32'(status_state), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
